// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// a helper that tells whether the sequencer can take a new operation.
package serial_sub_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic is_ready(input state_t s);
    return (s == S_IDLE) || (s == S_DONE);
  endfunction

endpackage

// File: rtl/serial_subtractor_fs_nand.sv
// One-bit full subtractor built purely from two-input NAND gates:
// diff = a ^ b ^ bin, bout = (~a & b) | (~(a ^ b) & bin).
module fs_nand (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  logic n1, n2, n3, x;
  logic m1, m2, m3;

  // n3 = ~(~a & b) and m3 = ~(~x & bin), so the borrow falls out of one more NAND
  assign n1   = ~(a & b);
  assign n2   = ~(a & n1);
  assign n3   = ~(b & n1);
  assign x    = ~(n2 & n3);
  assign m1   = ~(x & bin);
  assign m2   = ~(x & m1);
  assign m3   = ~(bin & m1);
  assign diff = ~(m2 & m3);
  assign bout = ~(n3 & m3);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: streams operands LSB first through a single
// fs_nand cell, carrying the borrow in a flop between cycles.
//
// state  | meaning
// IDLE   | waiting for start
// RUN    | one bit pair per cycle through the cell (WIDTH cycles)
// DONE   | diff/bout just updated; done pulses; may accept a new start
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, acc;
  logic             brw;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last;
  logic             cell_diff, cell_bout;

  fs_nand u_cell (
    .a    (sa[0]),
    .b    (sb[0]),
    .bin  (brw),
    .diff (cell_diff),
    .bout (cell_bout)
  );

  assign last = (cnt == CNT_LAST);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      sa    <= '0;
      sb    <= '0;
      acc   <= '0;
      brw   <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept && is_ready(state)) begin
        sa  <= a;
        sb  <= b;
        brw <= bin;
        cnt <= '0;
        acc <= '0;
      end else if (state == S_RUN) begin
        sa  <= sa >> 1;
        sb  <= sb >> 1;
        brw <= cell_bout;
        acc <= {cell_diff, acc[WIDTH-1:1]};
        cnt <= cnt + CNT_W'(1);
        // Result registers only move on the final bit so they hold between ops
        if (last) begin
          diff <= {cell_diff, acc[WIDTH-1:1]};
          bout <= cell_bout;
        end
      end
    end
  end

endmodule
